// File: rtl/nf10_identifier_reader_if.sv
// nf10_identifier_reader_if: AXI4-Lite bus bundle between the identifier reader and the identifier slave.
// master: drives AR/R-ready and the write channels, which are tied off. slave: the opposite directions.
interface nf10_identifier_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/nf10_identifier_reader.sv
// nf10_identifier_reader: AXI4-Lite master that sweeps C_NUM_WORDS identifier words into a local buffer.
// Ports: M_AXI_ACLK/M_AXI_ARESET clock and sync active-high reset; start/busy/done sweep control;
// rresp_err/timeout_err/words_read status of the last sweep; rd_index/rd_data registered buffer read;
// id_match word-0 compare; m AXI4-Lite master bus (write channels tied off).
// Optional macro NF10_IDENTIFIER_READER_CHECK_EN builds the word-0 compare against C_EXPECTED_ID.
module nf10_identifier_reader #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_ID_BASEADDR      = 32'h0000_0000,
  parameter int          C_NUM_WORDS        = 16,
  parameter int          C_TIMEOUT          = 255,
  parameter logic [31:0] C_EXPECTED_ID      = 32'h0000_0000
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rresp_err,
  output logic        timeout_err,
  output logic [4:0]  words_read,
  input  logic [3:0]  rd_index,
  output logic [31:0] rd_data,
  output logic        id_match,
  nf10_identifier_reader_if.master m
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam logic [3:0]  last_idx = 4'(C_NUM_WORDS - 1);
  localparam logic [15:0] tmo_lim  = 16'(C_TIMEOUT - 1);
  state_t state;
  logic [3:0] idx;
  logic [15:0] timer;
  logic [C_M_AXI_DATA_WIDTH-1:0] buffer [16];
  logic unused_in;
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(input logic [3:0] i);
    return C_M_AXI_ADDR_WIDTH'(C_ID_BASEADDR + {26'd0, i, 2'b00});
  endfunction
  assign m.awaddr  = '0;
  assign m.awvalid = 1'b0;
  assign m.wdata   = '0;
  assign m.wstrb   = '0;
  assign m.wvalid  = 1'b0;
  assign m.bready  = 1'b1;
  assign unused_in = ^{m.awready, m.wready, m.bresp, m.bvalid};
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rresp_err   <= 1'b0;
      timeout_err <= 1'b0;
      words_read  <= '0;
      m.araddr    <= '0;
      m.arvalid   <= 1'b0;
      m.rready    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= ADDR;
          idx         <= '0;
          timer       <= '0;
          busy        <= 1'b1;
          rresp_err   <= 1'b0;
          timeout_err <= 1'b0;
          words_read  <= '0;
          m.araddr    <= word_addr(4'd0);
          m.arvalid   <= 1'b1;
        end
        ADDR: if (m.arready) begin
          state     <= DATA;
          timer     <= '0;
          m.arvalid <= 1'b0;
          m.rready  <= 1'b1;
        end else if (timer == tmo_lim) begin
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          timeout_err <= 1'b1;
          m.arvalid   <= 1'b0;
        end else begin
          timer <= timer + 16'd1;
        end
        DATA: if (m.rvalid) begin
          timer      <= '0;
          words_read <= words_read + 5'd1;
          rresp_err  <= rresp_err | (|m.rresp);
          m.rready   <= 1'b0;
          if (idx == last_idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ADDR;
            idx       <= idx + 4'd1;
            m.araddr  <= word_addr(idx + 4'd1);
            m.arvalid <= 1'b1;
          end
        end else if (timer == tmo_lim) begin
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          timeout_err <= 1'b1;
          m.rready    <= 1'b0;
        end else begin
          timer <= timer + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Buffer deliberately has no reset; errored words are stored like good ones.
  always_ff @(posedge M_AXI_ACLK) begin
    if (state == DATA && m.rvalid) buffer[idx] <= m.rdata;
  end
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) rd_data <= '0;
    else rd_data <= buffer[rd_index];
  end
`ifdef NF10_IDENTIFIER_READER_CHECK_EN
  logic cmp_pending;
  // Compare one cycle after word 0 lands, reading it back from the buffer.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      cmp_pending <= 1'b0;
      id_match    <= 1'b0;
    end else begin
      cmp_pending <= state == DATA && m.rvalid && idx == 4'd0;
      if (state == IDLE && start) id_match <= 1'b0;
      else if (cmp_pending) id_match <= buffer[0] == C_EXPECTED_ID;
    end
  end
`else
  localparam logic unused_expected = ^C_EXPECTED_ID;
  assign id_match = 1'b0;
`endif
endmodule

// File: tb/tb_nf10_identifier_reader.sv
// tb_nf10_identifier_reader: directed vector bench with a configurable-latency identifier slave.
module tb_nf10_identifier_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rd_index = 4'd0;
  logic        busy, done, rresp_err, timeout_err, id_match;
  logic [4:0]  words_read;
  logic [31:0] rd_data;
  int errors = 0;
  int checks = 0;

  nf10_identifier_reader_if bus ();

  nf10_identifier_reader #(
    .C_TIMEOUT(20),
    .C_EXPECTED_ID(32'h0000DA7E)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .rresp_err(rresp_err),
    .timeout_err(timeout_err),
    .words_read(words_read),
    .rd_index(rd_index),
    .rd_data(rd_data),
    .id_match(id_match),
    .m(bus)
  );

  always #5 clk = ~clk;

  // Slave model: ARREADY after ar_delay waiting cycles, RVALID after r_delay DATA cycles.
  int          ar_delay = 0;
  int          r_delay = 0;
  logic [4:0]  err_word = 5'd16;
  logic [4:0]  hang_word = 5'd16;
  logic [31:0] dbase = 32'hA000_0000;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  logic        pend = 1'b0;
  logic [3:0]  cur = 4'd0;
  logic [31:0] addr_q [$];
  int          unstable = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  assign bus.arready = bus.arvalid && ar_cnt >= ar_delay;
  assign bus.rvalid  = pend && r_cnt >= r_delay && {1'b0, cur} != hang_word;
  assign bus.rdata   = dbase + 32'(cur);
  assign bus.rresp   = ({1'b0, cur} == err_word) ? 2'b10 : 2'b00;
  assign bus.awready = 1'b0;
  assign bus.wready  = 1'b0;
  assign bus.bresp   = 2'b00;
  assign bus.bvalid  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      ar_cnt    <= 0;
      r_cnt     <= 0;
      prev_wait <= 1'b0;
    end else begin
      if (prev_wait && !timeout_err && (!bus.arvalid || bus.araddr != prev_addr)) unstable <= unstable + 1;
      prev_wait <= bus.arvalid && !bus.arready;
      prev_addr <= bus.araddr;
      if (bus.arvalid && bus.arready) begin
        pend   <= 1'b1;
        cur    <= bus.araddr[5:2];
        ar_cnt <= 0;
        addr_q.push_back(bus.araddr);
      end else if (bus.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) begin
        pend  <= 1'b0;
        r_cnt <= 0;
      end else if (pend) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  typedef struct {
    int          ard;
    int          rdl;
    logic [4:0]  err;
    logic [4:0]  hang;
    logic [31:0] base;
    int          words;
    logic        rerr;
    logic        tmo;
    int          cyc;
    int          naddr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 1;
    while (!done && cyc < lim) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic rd_chk(input logic [3:0] i, input logic [31:0] exp);
    rd_index = i;
    @(posedge clk);
    #1 chk("rd_data", rd_data, exp);
  endtask

  task automatic chk_addrs(input int n);
    int bad = 0;
    for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != 32'(4 * k)) bad++;
    chk("addr_count", 32'(addr_q.size()), 32'(n));
    chk("addr_order", 32'(bad), 32'd0);
  endtask

  initial begin
    vec_t tbl [7];
    int cyc, dn, k;
    logic exp_id;
    tbl[0] = '{0,  0,  5'd16, 5'd16, 32'hA000_0000, 16, 1'b0, 1'b0, 33,  16};
    tbl[1] = '{3,  4,  5'd16, 5'd16, 32'hA000_0000, 16, 1'b0, 1'b0, 145, 16};
    tbl[2] = '{0,  0,  5'd3,  5'd16, 32'hA000_0000, 16, 1'b1, 1'b0, 33,  16};
    tbl[3] = '{0,  0,  5'd16, 5'd2,  32'hA000_0000, 2,  1'b0, 1'b1, 26,  3};
    tbl[4] = '{19, 0,  5'd16, 5'd16, 32'h0000_DA7E, 16, 1'b0, 1'b0, 337, 16};
    tbl[5] = '{0,  19, 5'd16, 5'd16, 32'h1234_5678, 16, 1'b0, 1'b0, 337, 16};
    tbl[6] = '{20, 0,  5'd16, 5'd16, 32'hA000_0000, 0,  1'b0, 1'b1, 21,  0};

    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {30'd0, rresp_err, timeout_err}, 32'd0);
    chk("rst_words", 32'(words_read), 32'd0);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_rready", 32'(bus.rready), 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_bready", 32'(bus.bready), 32'd1);
    chk("rst_wr_tie", {29'd0, bus.awvalid, bus.wvalid, |bus.wstrb}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_id_match", 32'(id_match), 32'd0);

    for (int n = 0; n < 7; n++) begin
      ar_delay  = tbl[n].ard;
      r_delay   = tbl[n].rdl;
      err_word  = tbl[n].err;
      hang_word = tbl[n].hang;
      dbase     = tbl[n].base;
      do_reset();
      addr_q.delete();
      pulse_start();
      wait_done(2000, cyc);
`ifdef NF10_IDENTIFIER_READER_CHECK_EN
      exp_id = tbl[n].base == 32'h0000DA7E && tbl[n].words > 0;
`else
      exp_id = 1'b0;
`endif
      chk("done_cycle", 32'(cyc), 32'(tbl[n].cyc));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("words_read", 32'(words_read), 32'(tbl[n].words));
      chk("rresp_err", 32'(rresp_err), 32'(tbl[n].rerr));
      chk("timeout_err", 32'(timeout_err), 32'(tbl[n].tmo));
      chk("id_match", 32'(id_match), 32'(exp_id));
      chk_addrs(tbl[n].naddr);
      @(posedge clk);
      #1 chk("done_width", 32'(done), 32'd0);
      chk("arvalid_after", 32'(bus.arvalid), 32'd0);
      chk("rready_after", 32'(bus.rready), 32'd0);
      if (tbl[n].words > 5) rd_chk(4'd5, tbl[n].base + 32'd5);
      if (tbl[n].words > 0) rd_chk(4'(tbl[n].words - 1), tbl[n].base + 32'(tbl[n].words - 1));
    end
    chk("araddr_stable", 32'(unstable), 32'd0);

    // start held high: busy starts are ignored, DONE-cycle start ignored, next IDLE start taken.
    ar_delay = 0; r_delay = 0; err_word = 5'd16; hang_word = 5'd16; dbase = 32'hA000_0000;
    do_reset();
    addr_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1 wait_done(200, cyc);
    chk("held_done_cycle", 32'(cyc), 32'd33);
    chk_addrs(16);
    @(posedge clk);
    #1 chk("done_cycle_start_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("idle_start_busy", 32'(busy), 32'd1);
    chk("idle_start_arvalid", 32'(bus.arvalid), 32'd1);
    chk("idle_start_araddr", bus.araddr, 32'd0);

    // start held through a sweep, reset during word 7.
    do_reset();
    addr_q.delete();
    start = 1'b1;
    dn = 0;
    k = 0;
    while (addr_q.size() < 8 && k < 200) begin
      @(posedge clk);
      #1 if (done) dn++;
      k++;
    end
    chk("midreset_addrs", 32'(addr_q.size()), 32'd8);
    chk("midreset_no_done", 32'(dn), 32'd0);
    chk("midreset_words_before", 32'(words_read), 32'd7);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_arvalid", 32'(bus.arvalid), 32'd0);
    chk("midreset_rready", 32'(bus.rready), 32'd0);
    chk("midreset_words", 32'(words_read), 32'd0);
    addr_q.delete();
    pulse_start();
    chk("restart_arvalid", 32'(bus.arvalid), 32'd1);
    chk("restart_araddr", bus.araddr, 32'd0);
    wait_done(200, cyc);
    chk("restart_done_cycle", 32'(cyc), 32'd33);
    chk_addrs(16);
    chk("restart_words", 32'(words_read), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nf10_identifier_reader.md
Name: nf10_identifier_reader

Overview:
- AXI4-Lite master that reads a block of identifier words from an identifier slave, one word per transaction.
- The identifier slave serves 16 x 32-bit ID words at BASE + 4*i.
- Read words land in a local buffer that host-side logic reads by index; status flags report bus errors and timeouts.
- Sits on the slave's AXI4-Lite interconnect port, as the initiator that the identifier slave answers.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_ID_BASEADDR, 32'h00000000, byte address of ID word 0.
- C_NUM_WORDS, 16, words read per sweep; legal range 1..16.
- C_TIMEOUT, 255, maximum cycles per channel wait before abort; legal range 1..65535.
- C_EXPECTED_ID, 32'h00000000, expected value of word 0 (used only with the optional feature).

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep ends (normal or aborted).
- rresp_err  out  1  sticky: any RRESP != 0 in the last sweep.
- timeout_err  out  1  sticky: the last sweep aborted on timeout.
- words_read  out  5  number of words captured in the last sweep.
- rd_index  in  4  buffer index.
- rd_data  out  32  buffer[rd_index], registered, 1-cycle latency.
- id_match  out  1  word 0 equals C_EXPECTED_ID (optional feature).
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY  out  per AXI  write channels tied off: AWVALID=0, WVALID=0, AWADDR=0, WDATA=0, WSTRB=0, BREADY=1.
- M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID  in  per AXI  ignored.

Behaviour:
- Clocking and reset:
  - Single clock M_AXI_ACLK; M_AXI_ARESET is synchronous, active-high.
  - Reset values: all outputs 0 except M_AXI_BREADY=1. Buffer contents are not reset.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - start=1 loads idx=0, clears rresp_err, timeout_err and words_read, sets busy, goes to ADDR.
- ADDR:
  - ARVALID=1, ARADDR = C_ID_BASEADDR + 4*idx.
  - ARADDR is held stable and ARVALID is not withdrawn until ARREADY.
  - ARVALID&ARREADY goes to DATA and clears the timer.
- DATA:
  - RREADY=1.
  - On RVALID: buffer[idx] <= RDATA, words_read += 1, and rresp_err |= (RRESP != 0). An errored word is still stored and the sweep continues.
  - If idx == C_NUM_WORDS-1, go to DONE; else idx+1 and return to ADDR.
  - Handshakes in consecutive cycles are legal: ARREADY in the same cycle ARVALID rises, and RVALID in the first DATA cycle.
- Timer:
  - 16-bit, counts cycles spent in ADDR or DATA without the awaited handshake.
  - Reaching C_TIMEOUT sets timeout_err, drops ARVALID/RREADY and goes to DONE.
  - words_read then holds the count of words captured before the abort.
- DONE:
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Sequencing:
  - A start while busy is ignored.
  - A start in the DONE cycle is ignored.
  - A start in the IDLE cycle immediately after DONE is accepted.
- Throughput: minimum 2 cycles per word, so C_NUM_WORDS=16 takes at least 32 cycles plus DONE.
- Reset mid-sweep: FSM returns to IDLE next cycle, ARVALID/RREADY deassert, flags clear, and no done pulse is issued.
- Buffer read port: rd_data updates one cycle after rd_index, independent of FSM state. Indices >= C_NUM_WORDS return stale or undefined contents.

Optional Feature:
- Macro: NF10_IDENTIFIER_READER_CHECK_EN.
- Defined:
  - A 1-cycle compare after word 0 captures sets id_match = (buffer[0] == C_EXPECTED_ID).
  - id_match is cleared at start and held until the next start.
  - A timeout before word 0 leaves id_match=0.
- Undefined: id_match is tied to 0, and no comparator or extra register is built.

Test Plan:
- Zero-wait slave, C_NUM_WORDS=16, slave returns 32'hA0000000+i -> 16 ARADDRs 0x00..0x3C in order; rd_index=5 reads 32'hA0000005; words_read=16; done pulse in cycle 33 after start; flags=0.
- Slave delays ARREADY 3 cycles and RVALID 4 cycles per word -> ARADDR and ARVALID held stable while waiting; all words correct; no timeout.
- Slave returns RRESP=2'b10 on word 3 only -> rresp_err=1; all 16 words stored; words_read=16.
- C_TIMEOUT=20, slave never asserts RVALID for word 2 -> timeout_err=1 after 20 DATA cycles; words_read=2; done pulses once; ARVALID=0 afterwards.
- start asserted in every cycle of a sweep, then reset at word 7 -> only one sweep occurs; after reset busy=0, done=0, ARVALID=0; a new start restarts at ARADDR=0x00.
- NF10_IDENTIFIER_READER_CHECK_EN defined, C_EXPECTED_ID=32'h0000DA7E, word 0 = 32'h0000DA7E -> id_match=1; with word 0 = 32'h0 -> id_match=0.
